// File: rtl/adc_valid_monitor.sv
// ADC data-valid qualifier: lock detection, dropout statistics and windowed
// valid count, packed into one registered 32-bit status word.
module adc_valid_monitor #(
  parameter int WIN_LOG2    = 16,
  parameter int LOCK_CYCLES = 64
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        adc_valid,
  input  logic        sw_clear,
  output logic [31:0] user_data_out
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  // Wide enough to hold a full-window count plus one and to compare against 0xFFFF.
  localparam int SUM_W = (WIN_LOG2 + 2 > 17) ? WIN_LOG2 + 2 : 17;
  localparam logic [WIN_LOG2-1:0] WIN_ONE = WIN_LOG2'(1);
  localparam logic [WIN_LOG2:0]   ACC_ZERO = '0;

  logic                v_q;
  logic                c_q;
  logic                c_prev;
  logic                locked;
  logic [15:0]         run_cnt;
  logic                sticky_drop;
  logic [12:0]         drop_count;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   acc;
  logic [15:0]         win_valid;
  logic                win_toggle;

  logic                clr_pulse;
  logic                drop_event;
  logic                win_term;
  logic [SUM_W-1:0]    win_sum;

  function automatic logic [15:0] sat_win(input logic [SUM_W-1:0] x);
    return (x > SUM_W'(17'h0FFFF)) ? 16'hFFFF : x[15:0];
  endfunction

  function automatic logic [12:0] sat_inc_drop(input logic [12:0] x);
    return (x == 13'h1FFF) ? x : x + 13'd1;
  endfunction

  assign clr_pulse  = c_q & ~c_prev;
  assign drop_event = locked & ~v_q;
  assign win_term   = &win_cnt;
  assign win_sum    = SUM_W'(acc) + SUM_W'(v_q);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      c_prev      <= 1'b0;
      locked      <= 1'b0;
      run_cnt     <= '0;
      sticky_drop <= 1'b0;
      drop_count  <= '0;
      win_cnt     <= '0;
      acc         <= '0;
      win_valid   <= '0;
      win_toggle  <= 1'b0;
    end else begin
      v_q    <= adc_valid;
      c_q    <= sw_clear;
      c_prev <= c_q;

      // Lock FSM is independent of the software clear.
      if (!locked) begin
        if (v_q) begin
          if (run_cnt == LOCK_LAST) begin
            locked  <= 1'b1;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + 16'd1;
          end
        end else begin
          run_cnt <= '0;
        end
      end else if (!v_q) begin
        locked <= 1'b0;
      end

      if (clr_pulse) begin
        drop_count  <= '0;
        sticky_drop <= 1'b0;
        win_cnt     <= '0;
        acc         <= '0;
        win_valid   <= '0;
      end else begin
        if (drop_event) begin
          sticky_drop <= 1'b1;
          drop_count  <= sat_inc_drop(drop_count);
        end
        win_cnt <= win_cnt + WIN_ONE;
        if (win_term) begin
          win_valid  <= sat_win(win_sum);
          acc        <= ACC_ZERO;
          win_toggle <= ~win_toggle;
        end else begin
          acc <= acc + (WIN_LOG2 + 1)'(v_q);
        end
      end
    end
  end

  assign user_data_out = {locked, sticky_drop, win_toggle, drop_count, win_valid};

endmodule

// File: tb/tb_adc_valid_monitor.sv
// Directed bench for adc_valid_monitor: an abstract per-cycle model checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_adc_valid_monitor;

  localparam int WL   = 4;
  localparam int LC   = 8;
  localparam int WLEN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        av, sc, av2, sc2;
  logic [31:0] out1, out2;
  int          checks = 0;
  int          errors = 0;
  logic        started = 1'b0;

  always #5 clk = ~clk;

  adc_valid_monitor #(.WIN_LOG2(WL), .LOCK_CYCLES(LC)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .adc_valid(av), .sw_clear(sc),
    .user_data_out(out1));

  adc_valid_monitor #(.WIN_LOG2(WL), .LOCK_CYCLES(1)) dut_sat (
    .user_clk(clk), .user_rst_n(rst_n), .adc_valid(av2), .sw_clear(sc2),
    .user_data_out(out2));

  typedef struct packed {
    int   streak;
    logic locked;
    int   drops;
    logic sticky;
    int   phase;
    int   wsum;
    int   wlast;
    logic tog;
  } mstate_t;

  // One processed sample: lock by consecutive-run length, count drops while
  // locked, and sum samples over fixed 16-sample windows.
  function automatic mstate_t step(input mstate_t s, input logic v, input logic clr,
                                   input int lockc);
    mstate_t n = s;
    if (!s.locked) begin
      if (v) begin
        n.streak = s.streak + 1;
        if (n.streak == lockc) begin
          n.locked = 1'b1;
          n.streak = 0;
        end
      end else begin
        n.streak = 0;
      end
    end else if (!v) begin
      n.locked = 1'b0;
      n.drops  = s.drops + 1;
      n.sticky = 1'b1;
    end
    if (clr) begin
      n.drops = 0; n.sticky = 1'b0; n.phase = 0; n.wsum = 0; n.wlast = 0;
    end else begin
      n.wsum  = s.wsum + int'(v);
      n.phase = s.phase + 1;
      if (n.phase == WLEN) begin
        n.wlast = n.wsum; n.wsum = 0; n.phase = 0; n.tog = ~s.tog;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] word_of(input mstate_t s);
    int d, w;
    d = (s.drops > 8191) ? 8191 : s.drops;
    w = (s.wlast > 65535) ? 65535 : s.wlast;
    return {s.locked, s.sticky, s.tog, 13'(d), 16'(w)};
  endfunction

  mstate_t m1, m2;
  logic mv1, mc1, mp1, mv2, mc2, mp2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0; m2 <= '0;
      mv1 <= 1'b0; mc1 <= 1'b0; mp1 <= 1'b0;
      mv2 <= 1'b0; mc2 <= 1'b0; mp2 <= 1'b0;
    end else begin
      m1  <= step(m1, mv1, mc1 & ~mp1, LC);
      m2  <= step(m2, mv2, mc2 & ~mp2, 1);
      mv1 <= av;  mc1 <= sc;  mp1 <= mc1;
      mv2 <= av2; mc2 <= sc2; mp2 <= mc2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_word", out1, rst_n ? word_of(m1) : 32'h0);
      check("model_word_sat", out2, rst_n ? word_of(m2) : 32'h0);
    end
  end

  task automatic lock_sequence(input string tag);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      check({tag, "_lock_bit"}, 32'(out1[31]), 32'(i == 9));
    end
    check({tag, "_status_clear"}, 32'(out1[30:16]), 32'h0);
  endtask

  task automatic wait_toggle(input logic ref_tog, output int n);
    n = 0;
    while (out1[29] == ref_tog && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int   n;
    logic t;
    rst_n = 1'b0; av = 1'b0; sc = 1'b0; av2 = 1'b0; sc2 = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    check("reset_word", out1, 32'h0);

    // Lock acquisition from reset release.
    #1 rst_n = 1'b1; av = 1'b1;
    lock_sequence("s1");

    // Continuous valid: full windows of 16, toggle period 16.
    repeat (40) @(posedge clk);
    #1 check("win_full", 32'(out1[15:0]), 32'd16);
    wait_toggle(out1[29], n);
    t = out1[29];
    wait_toggle(t, n);
    check("toggle_period", 32'(n), 32'd16);

    // Single dropout while locked.
    @(posedge clk); #2 av = 1'b0;
    @(posedge clk); #1 t = out1[29];
    #1 av = 1'b1;
    @(posedge clk); #1;
    check("drop_lock", 32'(out1[31]), 32'd0);
    check("drop_sticky", 32'(out1[30]), 32'd1);
    check("drop_count1", 32'(out1[28:16]), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("relock_bit", 32'(out1[31]), 32'(i == 8));
    end
    if (out1[29] == t) wait_toggle(t, n);
    check("drop_window", 32'(out1[15:0]), 32'd15);

    // Alternating valid: 8 per window.
    repeat (48) begin
      @(posedge clk); #2 av = ~av;
    end
    #1 check("win_alt", 32'(out1[15:0]), 32'd8);
    @(posedge clk); #2 av = 1'b1;
    repeat (30) @(posedge clk);

    // Clear coincident with a drop, then held high across further drops.
    #2 sc = 1'b1; av = 1'b0;
    @(posedge clk); #2 av = 1'b1;
    @(posedge clk); #1;
    check("clr_drop_lock", 32'(out1[31]), 32'd0);
    check("clr_drop_sticky", 32'(out1[30]), 32'd0);
    check("clr_drop_count", 32'(out1[28:16]), 32'd0);
    #1;
    for (int k = 0; k < 9; k++) begin
      repeat (10) @(posedge clk);
      #2 av = 1'b0;
      @(posedge clk); #2 av = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 check("held_clr_count", 32'(out1[28:16]), 32'd9);
    check("held_clr_sticky", 32'(out1[30]), 32'd1);
    #1 sc = 1'b0;

    // Drop counter saturation on the LOCK_CYCLES=1 instance.
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2 av2 = 1'b1;
      @(posedge clk); #2 av2 = 1'b0;
    end
    @(posedge clk); #2 av2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("sat_count100", 32'(out2[28:16]), 32'd100);
    for (int k = 0; k < 8150; k++) begin
      @(posedge clk); #2 av2 = 1'b1;
      @(posedge clk); #2 av2 = 1'b0;
    end
    @(posedge clk); #2 av2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("sat_count_max", 32'(out2[28:16]), 32'h1FFF);
    check("sat_locked", 32'(out2[31]), 32'd1);

    // Asynchronous reset between clock edges, then full lock restart.
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", out1, 32'h0);
    check("async_reset_sat", out2, 32'h0);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    lock_sequence("s6");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_valid_monitor.md
Name: adc_valid_monitor

Overview:
Qualifies the ADC data-valid strobe in the ADC clock domain and packs lock state, dropout statistics and a windowed valid count into one 32-bit status word. It sits directly upstream of the adc_in_valid software register. user_data_out drives that register's user_data_in, so the PPC can poll ADC link health. A software-clear input, driven from a ppc2simulink register, resets the statistics.

Parameters:
WIN_LOG2, 16, measurement window length is 2^WIN_LOG2 user_clk cycles; legal range 2..24
LOCK_CYCLES, 64, consecutive valid cycles required to declare lock; legal range 1..65535

Ports:
user_clk  in  1  ADC-domain clock; the only clock
user_rst_n  in  1  asynchronous active-low reset
adc_valid  in  1  raw data-valid strobe from the ADC interface
sw_clear  in  1  level from software register; the rising edge clears statistics
user_data_out  out  32  status word to the adc_in_valid register

Behaviour:
- Reset (user_rst_n=0, asynchronous): all registers and outputs go to 0 immediately. State is UNLOCKED and user_data_out=0x00000000.
- Input stage: adc_valid and sw_clear are each registered once, giving v_q and c_q. c_prev holds c_q delayed one cycle. clr_pulse = c_q & ~c_prev, a single cycle per rising edge. Holding sw_clear high does not re-clear.
- All logic operates on v_q. user_data_out is a registered output. Latency from adc_valid to user_data_out is 2 cycles.
- Status word fields:
  - [31] locked.
  - [30] sticky_drop.
  - [29] win_toggle.
  - [28:16] drop_count, 13 bits, saturating at 0x1FFF.
  - [15:0] win_valid, the valid count from the last completed window, saturating at 0xFFFF.
- Lock FSM:
  - UNLOCKED: run_cnt (16 bits) increments on v_q=1 and clears on v_q=0. When v_q=1 and run_cnt==LOCK_CYCLES-1, go to LOCKED and clear run_cnt.
  - LOCKED: on v_q=0 (a drop event), go to UNLOCKED, set sticky_drop, and increment drop_count unless it is saturated.
  - Drops while UNLOCKED are not counted.
- Window:
  - win_cnt (WIN_LOG2 bits) is free-running.
  - acc (WIN_LOG2+1 bits) adds v_q every cycle.
  - On win_cnt terminal count (all ones): win_valid <= min(acc+v_q, 0xFFFF); acc <= 0; win_toggle inverts.
- clr_pulse zeroes drop_count, sticky_drop, win_cnt, acc and win_valid, and leaves win_toggle unchanged.
  - Clear does not change the lock FSM or run_cnt.
  - Clear coincident with a drop: clear wins (count 0, sticky 0), but the FSM still goes to UNLOCKED.
  - Clear coincident with a window terminal count: clear wins; no toggle, no snapshot.
- Reset mid-window or mid-lock: full restart. Lock is reacquired only after LOCK_CYCLES fresh valid cycles.

Test Plan:
- Bench parameters for all scenarios: WIN_LOG2=4, LOCK_CYCLES=8.
- Scenario 1, lock: release reset, hold adc_valid=1 from cycle 0 -> bit31 rises at cycle 9 (8 valid cycles + 2 latency, first valid at 0). Bits[30:16]=0.
- Scenario 2, window: adc_valid=1 continuously -> bit29 toggles every 16 cycles; bits[15:0]=16. With adc_valid alternating 1/0 -> bits[15:0]=8.
- Scenario 3, single dropout: while locked, one cycle of adc_valid=0 -> two cycles later bit31=0, bit30=1, drop_count=1. Bit31 returns 8 cycles after valid resumes. The affected window reports 15.
- Scenario 4, saturation: with LOCK_CYCLES=1, toggle adc_valid 1/0 for more than 8200 periods -> drop_count holds at 0x1FFF and does not wrap.
- Scenario 5, clear: sw_clear rising in the same cycle as a drop -> drop_count=0 and bit30=0. Holding sw_clear high for 100 cycles with further drops -> counting resumes after the single clear.
- Scenario 6, asynchronous reset: assert user_rst_n=0 mid-window, between clock edges -> user_data_out=0 with no clock edge. After release, the lock sequence repeats as in scenario 1.
